fullchip_inst_sequencer: RTL and testbench

//  Host-side controller directly upstream of fullchip: generates the 19-bit inst word and mem_in bus
//  for one attention tile. Runs Q write, K write, K load, execute and ofifo->pmem drain autonomously.

---
 rtl/fullchip_pkg.sv | 21 ++
 rtl/phase_counter.sv | 23 ++
 rtl/fullchip_inst_sequencer.sv | 134 +++++++++++++
 tb/tb_fullchip_inst_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fullchip_pkg.sv
// fullchip_pkg: instruction bit map, counter width and sequencer state encoding for fullchip
package fullchip_pkg;
  localparam int INST_W        = 19;
  localparam int INST_DIV      = 18;
  localparam int INST_ACC      = 17;
  localparam int INST_OFIFO_RD = 16;
  localparam int INST_QK_ADD   = 12;
  localparam int INST_PMEM_ADD = 8;
  localparam int INST_EXECUTE  = 7;
  localparam int INST_LOAD     = 6;
  localparam int INST_QMEM_RD  = 5;
  localparam int INST_QMEM_WR  = 4;
  localparam int INST_KMEM_RD  = 3;
  localparam int INST_KMEM_WR  = 2;
  localparam int INST_PMEM_RD  = 1;
  localparam int INST_PMEM_WR  = 0;
  localparam int CNT_W         = 5;
  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_GAP, S_LOAD, S_WAIT1, S_EXEC, S_WAIT2, S_DRAIN, S_DONE
  } seq_state_t;
endpackage

// File: rtl/phase_counter.sv
// phase_counter: up-counter cleared by ld_i, advanced by en_i, flags cnt_o == tc_i
//   clk_i, rst_ni : clock, async active-low reset
//   ld_i, en_i    : clear to zero (priority), count enable
//   tc_i          : terminal value; tc_o high while cnt_o equals it
module phase_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic [W-1:0] tc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else if (ld_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + W'(1);
  assign cnt_o = cnt_q;
  assign tc_o  = cnt_q == tc_i;
endmodule

// File: rtl/fullchip_inst_sequencer.sv
// fullchip_inst_sequencer: drives fullchip inst/mem_in through Q write, K write, K load, execute and pmem drain
//   clk_i, rst_ni           : clock, async active-low reset
//   start_i, num_q_i        : begin a tile with num_q_i+1 Q vectors (IDLE only)
//   abort_i                 : synchronous return to IDLE
//   in_data_i/valid/ready   : host Q then K vectors
//   mem_in_o, inst_o        : registered fullchip data and instruction
//   busy_o, done_o          : not idle, one-cycle tile completion pulse
module fullchip_inst_sequencer
  import fullchip_pkg::*;
#(
  parameter int bw      = 8,
  parameter int pr      = 16,
  parameter int col     = 8,
  parameter int GAP_CYC = 2,
  parameter int EXE_LAT = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [3:0]        num_q_i,
  input  logic              abort_i,
  input  logic [pr*bw-1:0]  in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [pr*bw-1:0]  mem_in_o,
  output logic [INST_W-1:0] inst_o,
  output logic              busy_o,
  output logic              done_o
);
  seq_state_t state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [pr*bw-1:0] mem_q, mem_d;
  logic done_q, done_d;
  logic [3:0] nq_q, nq_d;
  logic [CNT_W-1:0] c, c_tc;
  logic [3:0] idx, idx_tc;
  logic c_last, idx_last, acc, phase_chg;
  assign in_ready_o = (state_q == S_QWR) || (state_q == S_KWR);
  assign busy_o     = state_q != S_IDLE;
  assign acc        = in_valid_i && in_ready_o;
  assign phase_chg  = state_d != state_q;
  assign idx_tc     = (state_q == S_KWR) ? 4'(col - 1) : nq_q;
  // Terminal cycle of the current timed phase; EXEC/DRAIN run for NQ cycles
  assign c_tc = (state_q == S_GAP)  ? CNT_W'(GAP_CYC - 1) :
                (state_q == S_LOAD) ? CNT_W'(col + 1) :
                (state_q == S_WAIT1 || state_q == S_WAIT2) ? CNT_W'(EXE_LAT - 1) :
                CNT_W'(nq_q);
  // Both counters restart on every state change, so each phase counts from 0
  phase_counter #(.W(CNT_W)) u_cyc (
    .clk_i(clk_i), .rst_ni(rst_ni), .ld_i(phase_chg), .en_i(1'b1),
    .tc_i(c_tc), .cnt_o(c), .tc_o(c_last)
  );
  phase_counter #(.W(4)) u_idx (
    .clk_i(clk_i), .rst_ni(rst_ni), .ld_i(phase_chg), .en_i(acc),
    .tc_i(idx_tc), .cnt_o(idx), .tc_o(idx_last)
  );
  always_comb begin
    state_d = state_q;
    inst_d  = '0;
    mem_d   = mem_q;
    done_d  = 1'b0;
    nq_d    = nq_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_QWR;
        nq_d    = num_q_i;
      end
      S_QWR: if (acc) begin
        inst_d[INST_QMEM_WR]       = 1'b1;
        inst_d[INST_QK_ADD +: 4]   = idx;
        mem_d                      = in_data_i;
        state_d                    = idx_last ? S_KWR : S_QWR;
      end
      S_KWR: if (acc) begin
        inst_d[INST_KMEM_WR]       = 1'b1;
        inst_d[INST_QK_ADD +: 4]   = idx;
        mem_d                      = in_data_i;
        state_d                    = idx_last ? S_GAP : S_KWR;
      end
      S_GAP:   state_d = c_last ? S_LOAD : S_GAP;
      // load is framed by one idle-read cycle on each side of the col K reads
      S_LOAD: begin
        inst_d[INST_LOAD] = 1'b1;
        if (c != '0 && !c_last) begin
          inst_d[INST_KMEM_RD]     = 1'b1;
          inst_d[INST_QK_ADD +: 4] = 4'(c - CNT_W'(1));
        end
        state_d = c_last ? S_WAIT1 : S_LOAD;
      end
      S_WAIT1: state_d = c_last ? S_EXEC : S_WAIT1;
      S_EXEC: begin
        inst_d[INST_EXECUTE]     = 1'b1;
        inst_d[INST_QMEM_RD]     = 1'b1;
        inst_d[INST_QK_ADD +: 4] = c[3:0];
        state_d = c_last ? S_WAIT2 : S_EXEC;
      end
      S_WAIT2: state_d = c_last ? S_DRAIN : S_WAIT2;
      S_DRAIN: begin
        inst_d[INST_OFIFO_RD]      = 1'b1;
        inst_d[INST_PMEM_WR]       = 1'b1;
        inst_d[INST_PMEM_ADD +: 4] = c[3:0];
        state_d = c_last ? S_DONE : S_DRAIN;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_i) begin
      state_d = S_IDLE;
      inst_d  = '0;
      mem_d   = mem_q;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      inst_q  <= '0;
      mem_q   <= '0;
      done_q  <= 1'b0;
      nq_q    <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      mem_q   <= mem_d;
      done_q  <= done_d;
      nq_q    <= nq_d;
    end
  assign inst_o   = inst_q;
  assign mem_in_o = mem_q;
  assign done_o   = done_q;
endmodule

// File: tb/tb_fullchip_inst_sequencer.sv
// tb_fullchip_inst_sequencer: vector table, random tiles against a fullchip-level model, abort/reset sequences
module tb_fullchip_inst_sequencer;
  import fullchip_pkg::*;
  localparam int BW = 8, PR = 16, COL = 8, GAP = 2, EXE = 10, DW = PR * BW;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [3:0] num_q = '0;
  logic [DW-1:0] in_data = '0, mem_in;
  logic [18:0] inst;
  logic in_ready, busy, done;
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  fullchip_inst_sequencer #(.bw(BW), .pr(PR), .col(COL), .GAP_CYC(GAP), .EXE_LAT(EXE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .num_q_i(num_q), .abort_i(abort),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mem_in_o(mem_in), .inst_o(inst), .busy_o(busy), .done_o(done)
  );
  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic int dot(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s = 0;
    for (int e = 0; e < PR; e++) s += $signed(a[e*BW +: BW]) * $signed(b[e*BW +: BW]);
    return s;
  endfunction
  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction
  // Fullchip-level model: memories, loaded K columns, ofifo queue of executed Q rows, pmem
  logic [DW-1:0] qv[16], kv[16], qmem[16], kmem[16], ldk[$], exq[$];
  logic [19:0] pm[16][COL];
  logic [3:0] qa, pa;
  int n_qwr, n_kwr, n_load, n_krd, n_exe, n_drn, n_done, n_bad;
  bit mon_en = 0;
  always @(negedge clk) if (mon_en) begin
    qa = inst[15:12];
    pa = inst[11:8];
    if (inst[18:17] != 2'b0 || inst[INST_PMEM_RD] || inst[0] != inst[16] ||
        $countones({inst[16], inst[7], inst[6], inst[4], inst[2]}) > 1 ||
        (inst[3] && !inst[6]) || (inst[5] && !inst[7])) n_bad++;
    if (inst[INST_QMEM_WR]) begin qmem[qa] = mem_in; n_qwr++; end
    if (inst[INST_KMEM_WR]) begin kmem[qa] = mem_in; n_kwr++; end
    if (inst[INST_LOAD]) n_load++;
    if (inst[INST_LOAD] && inst[INST_KMEM_RD]) begin ldk.push_back(kmem[qa]); n_krd++; end
    if (inst[INST_EXECUTE] && inst[INST_QMEM_RD]) begin exq.push_back(qmem[qa]); n_exe++; end
    if (inst[INST_OFIFO_RD] && inst[INST_PMEM_WR]) begin
      n_drn++;
      if (exq.size() > 0) begin
        logic [DW-1:0] q;
        q = exq.pop_front();
        for (int j = 0; j < COL && j < ldk.size(); j++) pm[pa][j] = 20'(dot(q, ldk[j]));
      end
    end
    if (done) n_done++;
  end
  // mode 0: full tile; 1: abort in EXEC cycle 3; 2: reset low in DRAIN
  task automatic run_tile(input int nqm1, input int bub, input int mode);
    int nq, sent, cyc, nz;
    bit acc, hit;
    logic [159:0] ar, er;
    nq = nqm1 + 1;
    for (int i = 0; i < nq; i++) qv[i] = rnd_vec();
    for (int j = 0; j < COL; j++) kv[j] = rnd_vec();
    n_qwr = 0; n_kwr = 0; n_load = 0; n_krd = 0; n_exe = 0; n_drn = 0; n_done = 0; n_bad = 0;
    ldk.delete();
    exq.delete();
    for (int i = 0; i < 16; i++) for (int j = 0; j < COL; j++) pm[i][j] = 'x;
    mon_en = (mode == 0);
    start = 1'b1;
    num_q = 4'(nqm1);
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    cyc = 0;
    while (sent < nq + COL && cyc < 2000) begin
      in_valid = ($urandom_range(99) >= bub);
      in_data = (sent < nq) ? qv[sent] : kv[sent - nq];
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    chk("vectors accepted", sent, nq + COL);
    hit = 0;
    while (!done && !hit && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (mode == 1 && inst[INST_EXECUTE] && inst[15:12] == 4'd2) hit = 1;
      if (mode == 2 && inst[INST_OFIFO_RD] && inst[11:8] == 4'd2) hit = 1;
    end
    if (mode == 1) begin
      chk("abort point reached", hit, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("abort next cycle", {inst, busy, in_ready, done}, 0);
      nz = 0;
      repeat (80) begin
        @(posedge clk); #1;
        if (inst != '0 || busy || done) nz++;
      end
      chk("idle after abort", nz, 0);
    end else if (mode == 2) begin
      chk("reset point reached", hit, 1);
      #2 rst_n = 1'b0;
      #1 chk("async reset in drain", {inst, busy, in_ready, done, mem_in}, 0);
      @(negedge clk) rst_n = 1'b1;
    end else begin
      chk("done seen", done, 1);
      if (bub == 0) chk("start to done latency", cyc, nq + COL + GAP + (COL + 2) + EXE + nq + EXE + nq + 1);
      chk("idle at done", {inst, busy, in_ready}, 0);
      @(posedge clk); #1;
      chk("done one pulse", done, 0);
      @(negedge clk);
      mon_en = 0;
      chk("qmem writes", n_qwr, nq);
      chk("kmem writes", n_kwr, COL);
      chk("load cycles", n_load, COL + 2);
      chk("kmem reads", n_krd, COL);
      chk("exec cycles", n_exe, nq);
      chk("drain cycles", n_drn, nq);
      chk("done count", n_done, 1);
      chk("phase exclusivity", n_bad, 0);
      for (int i = 0; i < nq; i++) begin
        for (int j = 0; j < COL; j++) begin
          ar[j*20 +: 20] = pm[i][j];
          er[j*20 +: 20] = 20'(dot(qv[i], kv[j]));
        end
        chk($sformatf("pmem row %0d nq %0d", i, nq), ar, er);
      end
    end
  endtask
  typedef struct {
    logic st, ab, vl;
    logic [3:0] nq;
    logic [DW-1:0] d;
    logic [18:0] ei;
    logic eb, er;
    logic [DW-1:0] em;
    string nm;
  } vec_t;
  function automatic vec_t mk(input logic st, input logic ab, input logic vl, input logic [3:0] nq,
                              input logic [DW-1:0] d, input logic [18:0] ei, input logic eb,
                              input logic er, input logic [DW-1:0] em, input string nm);
    vec_t v;
    v.st = st; v.ab = ab; v.vl = vl; v.nq = nq; v.d = d;
    v.ei = ei; v.eb = eb; v.er = er; v.em = em; v.nm = nm;
    return v;
  endfunction
  initial begin
    logic [DW-1:0] d0, d1, d2, d3;
    vec_t tv[14];
    d0 = {16{8'hA1}}; d1 = {16{8'h5C}}; d2 = {16{8'h3E}}; d3 = {16{8'hF7}};
    tv[0]  = mk(1'b1, 1'b0, 1'b0, 4'd1, '0, 19'h0,    1'b1, 1'b1, '0, "start nq2");
    tv[1]  = mk(1'b0, 1'b0, 1'b1, 4'd0, d0, 19'h0010, 1'b1, 1'b1, d0, "q0 write");
    tv[2]  = mk(1'b0, 1'b0, 1'b0, 4'd0, '0, 19'h0,    1'b1, 1'b1, d0, "q bubble");
    tv[3]  = mk(1'b0, 1'b0, 1'b1, 4'd0, d1, 19'h1010, 1'b1, 1'b1, d1, "q1 write");
    tv[4]  = mk(1'b0, 1'b0, 1'b0, 4'd0, '0, 19'h0,    1'b1, 1'b1, d1, "k bubble");
    tv[5]  = mk(1'b0, 1'b0, 1'b1, 4'd0, d2, 19'h0004, 1'b1, 1'b1, d2, "k0 write");
    tv[6]  = mk(1'b0, 1'b0, 1'b1, 4'd0, d3, 19'h1004, 1'b1, 1'b1, d3, "k1 write");
    tv[7]  = mk(1'b1, 1'b0, 1'b0, 4'd5, '0, 19'h0,    1'b1, 1'b1, d3, "start while busy");
    tv[8]  = mk(1'b0, 1'b1, 1'b1, 4'd0, d2, 19'h0,    1'b0, 1'b0, d3, "abort beats accept");
    tv[9]  = mk(1'b0, 1'b0, 1'b1, 4'd0, d1, 19'h0,    1'b0, 1'b0, d3, "valid in idle");
    tv[10] = mk(1'b1, 1'b1, 1'b0, 4'd3, '0, 19'h0,    1'b0, 1'b0, d3, "abort beats start");
    tv[11] = mk(1'b0, 1'b0, 1'b0, 4'd0, '0, 19'h0,    1'b0, 1'b0, d3, "still idle");
    tv[12] = mk(1'b1, 1'b0, 1'b0, 4'd0, '0, 19'h0,    1'b1, 1'b1, d3, "start nq1");
    tv[13] = mk(1'b0, 1'b1, 1'b0, 4'd0, '0, 19'h0,    1'b0, 1'b0, d3, "abort in qwr");
    repeat (3) @(posedge clk);
    #1 chk("in reset", {inst, busy, in_ready, done, mem_in}, 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("after reset", {inst, busy, in_ready, done, mem_in}, 0);
    foreach (tv[i]) begin
      start = tv[i].st; abort = tv[i].ab; in_valid = tv[i].vl; num_q = tv[i].nq; in_data = tv[i].d;
      @(posedge clk); #1;
      chk(tv[i].nm, {inst, busy, in_ready, done, mem_in}, {tv[i].ei, tv[i].eb, tv[i].er, 1'b0, tv[i].em});
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    run_tile(7, 0, 0);
    run_tile(7, 40, 0);
    run_tile(15, 0, 0);
    run_tile(0, 0, 0);
    repeat (3) run_tile($urandom_range(15), $urandom_range(50), 0);
    run_tile(7, 0, 1);
    run_tile(7, 0, 0);
    run_tile(7, 0, 2);
    run_tile(7, 20, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
